// File: rtl/omp_pkg.sv
// Shared parameters and state encoding for the OMP atom-selection stage.
package omp_pkg;
    localparam int COLS   = 64;
    localparam int IDX_W  = 6;
    localparam int DOT_W  = 48;
    localparam int ITER_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        SCAN     = 3'd2,
        COMMIT   = 3'd3,
        WAIT_UPD = 3'd4,
        FINISH   = 3'd5
    } state_t;
endpackage

// File: rtl/omp_atom_select_if.sv
// Dot-product engine and residual-update handshake bundle.
interface omp_atom_select_if;
    import omp_pkg::*;

    logic             dp_start;
    logic             dp_col_done;
    logic [IDX_W-1:0] dp_col_idx;
    logic [DOT_W-1:0] dp_dot;
    logic             dp_all_done;
    logic             upd_req;
    logic             upd_ack;

    modport master (
        output dp_start, upd_req,
        input  dp_col_done, dp_col_idx, dp_dot, dp_all_done, upd_ack
    );

    modport slave (
        input  dp_start, upd_req,
        output dp_col_done, dp_col_idx, dp_dot, dp_all_done, upd_ack
    );
endinterface

// File: rtl/omp_abs_max.sv
// Running |value| maximum over eligible candidates; ties keep the first seen.
module omp_abs_max
    import omp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld,
    input  logic             eligible,
    input  logic [IDX_W-1:0] idx,
    input  logic [DOT_W-1:0] val,
    output logic [IDX_W-1:0] best_idx,
    output logic [DOT_W-1:0] best_mag,
    output logic             best_valid
);
    localparam logic [DOT_W-1:0] MIN_NEG = {1'b1, {(DOT_W-1){1'b0}}};
    localparam logic [DOT_W-1:0] MAX_POS = ~MIN_NEG;

    logic [DOT_W-1:0] mag;
    logic             take;

    // The most negative value has no positive twin, so it saturates.
    always_comb begin
        mag = val;
        if (val == MIN_NEG)
            mag = MAX_POS;
        else if (val[DOT_W-1])
            mag = ~val + DOT_W'(1);
    end

    assign take = vld && eligible && (!best_valid || mag > best_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_idx   <= '0;
            best_mag   <= '0;
            best_valid <= 1'b0;
        end else if (clr) begin
            best_idx   <= '0;
            best_mag   <= '0;
            best_valid <= 1'b0;
        end else if (take) begin
            best_idx   <= idx;
            best_mag   <= mag;
            best_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/omp_atom_select.sv
// OMP iteration controller: launch dot products, pick the best unused
// column, commit it and hand off to the residual update, K times.
module omp_atom_select
    import omp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ITER_W-1:0]   k_target,
    omp_atom_select_if.master   bus,
    output logic                sel_valid,
    output logic [IDX_W-1:0]    sel_idx,
    output logic [DOT_W-1:0]    sel_mag,
    output logic [ITER_W-1:0]   iter,
    output logic [COLS-1:0]     support_mask,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t            state_q, state_d;
    logic [ITER_W-1:0] k_q, iter_q;
    logic [COLS-1:0]   mask_q;
    logic [IDX_W-1:0]  sel_idx_q, best_idx;
    logic [DOT_W-1:0]  sel_mag_q, best_mag;
    logic              best_valid, dp_start_q, done_q, err_q;
    logic              go, commit_ok, commit_err;

    omp_abs_max u_max (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state_q == LAUNCH),
        .vld        (state_q == SCAN && bus.dp_col_done),
        .eligible   (!mask_q[bus.dp_col_idx]),
        .idx        (bus.dp_col_idx),
        .val        (bus.dp_dot),
        .best_idx   (best_idx),
        .best_mag   (best_mag),
        .best_valid (best_valid)
    );

    assign go         = state_q == IDLE && start && !abort;
    assign commit_ok  = state_q == COMMIT && best_valid && !abort;
    assign commit_err = state_q == COMMIT && !best_valid && !abort;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = (k_target == '0) ? FINISH : LAUNCH;
            LAUNCH:   state_d = SCAN;
            SCAN:     if (bus.dp_all_done) state_d = COMMIT;
            COMMIT:   state_d = best_valid ? WAIT_UPD : FINISH;
            WAIT_UPD: if (bus.upd_ack) state_d = (iter_q == k_q) ? FINISH : LAUNCH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            iter_q     <= '0;
            mask_q     <= '0;
            sel_idx_q  <= '0;
            sel_mag_q  <= '0;
            dp_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dp_start_q <= state_q == LAUNCH && !abort;
            done_q     <= state_q == FINISH && !abort;
            if (go) begin
                k_q    <= k_target;
                iter_q <= '0;
                mask_q <= '0;
                err_q  <= 1'b0;
            end
            if (commit_ok) begin
                mask_q    <= mask_q | (COLS'(1) << best_idx);
                iter_q    <= iter_q + ITER_W'(1);
                sel_idx_q <= best_idx;
                sel_mag_q <= best_mag;
            end
            if (commit_err) err_q <= 1'b1;
        end
    end

    // The commit cycle shows the winner directly so sel_valid lands one
    // cycle after dp_all_done.
    assign sel_valid    = commit_ok;
    assign sel_idx      = commit_ok ? best_idx : sel_idx_q;
    assign sel_mag      = commit_ok ? best_mag : sel_mag_q;
    assign iter         = iter_q;
    assign support_mask = mask_q;
    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign err          = err_q;
    assign bus.dp_start = dp_start_q;
    assign bus.upd_req  = state_q == WAIT_UPD;
endmodule

// File: tb/tb_omp_atom_select.sv
// Directed, table-driven bench for omp_atom_select with an emulated
// dot-product engine and residual-update responder.
module tb_omp_atom_select;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  k_target = '0;
    logic        sel_valid;
    logic [5:0]  sel_idx;
    logic [47:0] sel_mag;
    logic [3:0]  iter;
    logic [63:0] support_mask;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    omp_atom_select_if bus();

    omp_atom_select dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .k_target     (k_target),
        .bus          (bus),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .sel_mag      (sel_mag),
        .iter         (iter),
        .support_mask (support_mask),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        k;
        logic [7:0][47:0]  dot;
        bit                coinc;
        bit                abrt;
        logic [5:0]        e_idx;
        logic [47:0]       e_mag;
        logic [63:0]       e_mask;
        logic [3:0]        e_iter;
        bit                e_err;
        int                e_dp;
        int                e_sel;
        int                e_done;
    } vec_t;

    localparam logic [47:0] MINV = {1'b1, 47'd0};
    localparam logic [47:0] MAXV = {1'b0, {47{1'b1}}};

    vec_t tab[9];

    function automatic vec_t mk(input logic [3:0] k, input logic [7:0][47:0] d,
                                input bit coinc, input bit abrt,
                                input logic [5:0] ei, input logic [47:0] em,
                                input logic [63:0] emask, input logic [3:0] eit,
                                input bit eerr, input int edp, input int esel,
                                input int edone);
        vec_t v;
        v.k = k; v.dot = d; v.coinc = coinc; v.abrt = abrt;
        v.e_idx = ei; v.e_mag = em; v.e_mask = emask; v.e_iter = eit;
        v.e_err = eerr; v.e_dp = edp; v.e_sel = esel; v.e_done = edone;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int cyc, pos, n_dp, n_sel, n_done, ack_cyc, ad_cyc, post;
        bit emitting, finished, aborted;
        string tag;
        tag = $sformatf("v%0d", n);
        cyc = 0; pos = 0; n_dp = 0; n_sel = 0; n_done = 0;
        ack_cyc = 0; ad_cyc = -10; post = 0;
        emitting = 0; finished = 0; aborted = 0;
        @(negedge clk);
        k_target = v.k;
        start = 1'b1;
        while (!finished && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            bus.upd_ack = 1'b0;
            bus.dp_col_done = 1'b0;
            bus.dp_all_done = 1'b0;
            if (aborted) begin
                if (post == 0) begin
                    chk({tag, " abort_upd_req"}, 64'(bus.upd_req), 64'd0);
                    chk({tag, " abort_busy"}, 64'(busy), 64'd0);
                end
                post++;
                if (post >= 4) finished = 1;
            end
            if (bus.dp_start) begin
                n_dp++;
                chk({tag, " dp_start_lat"}, 64'(cyc - ack_cyc), 64'd2);
                emitting = 1;
                pos = 0;
            end
            if (sel_valid) begin
                n_sel++;
                chk({tag, " sel_lat"}, 64'(cyc - ad_cyc), 64'd1);
            end
            if (done) begin
                n_done++;
                if (v.k == 4'd0) chk({tag, " k0_done_lat"}, 64'(cyc), 64'd2);
                finished = 1;
            end
            if (emitting) begin
                if (pos < 8) begin
                    bus.dp_col_done = 1'b1;
                    bus.dp_col_idx = 6'(pos);
                    bus.dp_dot = v.dot[pos];
                    if (pos == 7 && v.coinc) begin
                        bus.dp_all_done = 1'b1;
                        emitting = 0;
                        ad_cyc = cyc;
                    end
                    pos++;
                end else begin
                    bus.dp_all_done = 1'b1;
                    emitting = 0;
                    ad_cyc = cyc;
                end
            end
            if (bus.upd_req && !aborted) begin
                if (v.abrt) begin
                    abort = 1'b1;
                    aborted = 1;
                end else begin
                    bus.upd_ack = 1'b1;
                    ack_cyc = cyc;
                end
            end
        end
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: got no end of run within 600 cycles", tag);
        end
        start = 1'b0; abort = 1'b0; bus.upd_ack = 1'b0;
        bus.dp_col_done = 1'b0; bus.dp_all_done = 1'b0;
        @(negedge clk);
        chk({tag, " sel_idx"}, 64'(sel_idx), 64'(v.e_idx));
        chk({tag, " sel_mag"}, 64'(sel_mag), 64'(v.e_mag));
        chk({tag, " mask"}, support_mask, v.e_mask);
        chk({tag, " iter"}, 64'(iter), 64'(v.e_iter));
        chk({tag, " err"}, 64'(err), 64'(v.e_err));
        chk({tag, " n_dp_start"}, 64'(n_dp), 64'(v.e_dp));
        chk({tag, " n_sel_valid"}, 64'(n_sel), 64'(v.e_sel));
        chk({tag, " n_done"}, 64'(n_done), 64'(v.e_done));
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bus.dp_col_done = 1'b0;
        bus.dp_col_idx = '0;
        bus.dp_dot = '0;
        bus.dp_all_done = 1'b0;
        bus.upd_ack = 1'b0;

        tab[0] = mk(4'd1, {48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd30, 48'(-50), 48'd10},
                    0, 0, 6'd1, 48'd50, 64'h2, 4'd1, 0, 1, 1, 1);
        tab[1] = mk(4'd2, {48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd30, 48'(-50), 48'd10},
                    0, 0, 6'd2, 48'd30, 64'h6, 4'd2, 0, 2, 2, 1);
        tab[2] = mk(4'd1, {48'(-100), 48'd0, 48'd0, 48'd0, 48'd100, 48'd0, 48'd0, 48'd0},
                    0, 0, 6'd3, 48'd100, 64'h8, 4'd1, 0, 1, 1, 1);
        tab[3] = mk(4'd1, {48'd7, 48'd0, MINV, 48'd5, 48'd4, 48'(-3), 48'd2, 48'd1},
                    0, 0, 6'd5, MAXV, 64'h20, 4'd1, 0, 1, 1, 1);
        tab[4] = mk(4'd1, {48'd200, 48'd11, 48'd10, 48'd9, 48'd8, 48'd7, 48'd6, 48'd5},
                    1, 0, 6'd7, 48'd200, 64'h80, 4'd1, 0, 1, 1, 1);
        tab[5] = mk(4'd3, {48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd30, 48'(-50), 48'd10},
                    0, 0, 6'd0, 48'd10, 64'h7, 4'd3, 0, 3, 3, 1);
        tab[6] = mk(4'd9, {48'd8, 48'd7, 48'd6, 48'd5, 48'd4, 48'd3, 48'd2, 48'd1},
                    0, 0, 6'd0, 48'd1, 64'hFF, 4'd8, 1, 9, 8, 1);
        tab[7] = mk(4'd0, {48'd8, 48'd7, 48'd6, 48'd5, 48'd4, 48'd3, 48'd2, 48'd1},
                    0, 0, 6'd0, 48'd1, 64'h0, 4'd0, 0, 0, 0, 1);
        tab[8] = mk(4'd2, {48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd30, 48'(-50), 48'd10},
                    0, 1, 6'd1, 48'd50, 64'h2, 4'd1, 0, 1, 1, 0);

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_iter", 64'(iter), 64'd0);
        chk("rst_mask", support_mask, 64'd0);
        chk("rst_sel", 64'({sel_valid, sel_idx}), 64'd0);
        chk("rst_mag", 64'(sel_mag), 64'd0);
        chk("rst_hs", 64'({bus.dp_start, bus.upd_req}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, tab[i]);

        // Acks and column results arriving while idle must not disturb state.
        bus.upd_ack = 1'b1;
        bus.dp_col_done = 1'b1;
        bus.dp_col_idx = 6'd9;
        bus.dp_dot = 48'd999;
        bus.dp_all_done = 1'b1;
        @(negedge clk);
        bus.upd_ack = 1'b0;
        bus.dp_col_done = 1'b0;
        bus.dp_all_done = 1'b0;
        @(negedge clk);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_mask", support_mask, 64'h2);
        chk("stray_sel", 64'(sel_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
